// File: rtl/ckong_sram_arbiter.sv
// Shares the ckong work/ROM SRAM between the core and the HPS ROM download. A byte is written 1 cycle after it is accepted.
// ioctl_wait is held high while a write is in flight; a one-deep skid slot absorbs back-to-back strobes, and further strobes are dropped and flagged.
module ckong_sram_arbiter #(
   parameter int AW         = 17,
   parameter int RESET_HOLD = 16
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   output logic          core_reset,
   input  logic [AW-1:0] core_addr,
   input  logic          core_we,
   input  logic [7:0]    core_dout,
   output logic [7:0]    core_din,
   output logic [AW-1:0] sram_addr,
   output logic          sram_we,
   output logic [7:0]    sram_din,
   input  logic [7:0]    sram_dout,
   output logic          dl_error
);

   localparam int CW = $clog2(RESET_HOLD) + 1;

   typedef enum logic [1:0] {RUN, DL_IDLE, DL_WR, HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] hold_cnt, hold_cnt_nxt;
   logic [AW-1:0] lat_addr, lat_addr_nxt;
   logic [7:0]    lat_dat, lat_dat_nxt;
   logic          slot_vld, slot_vld_nxt;
   logic          dl_error_nxt;
   logic          dl_prev;
   logic          dl_start;
   logic          wr_in_range;

   assign dl_start    = ioctl_download && !dl_prev && (ioctl_index == 8'd0);
   assign wr_in_range = ((ioctl_addr >> AW) == 25'd0);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state    <= HOLD;
         hold_cnt <= '0;
         lat_addr <= '0;
         lat_dat  <= '0;
         slot_vld <= 1'b0;
         dl_error <= 1'b0;
         dl_prev  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         lat_addr <= lat_addr_nxt;
         lat_dat  <= lat_dat_nxt;
         slot_vld <= slot_vld_nxt;
         dl_error <= dl_error_nxt;
         dl_prev  <= ioctl_download;
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      lat_addr_nxt = lat_addr;
      lat_dat_nxt  = lat_dat;
      slot_vld_nxt = slot_vld;
      dl_error_nxt = dl_error;
      case (state)
         RUN, HOLD: begin
            if (dl_start) begin
               state_nxt    = DL_IDLE;
               hold_cnt_nxt = '0;
               slot_vld_nxt = 1'b0;
               dl_error_nxt = 1'b0;
            end else if (state == HOLD) begin
               if (hold_cnt == CW'(RESET_HOLD - 1))
                  state_nxt = RUN;
               else
                  hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         DL_IDLE: begin
            // A strobe coincident with the download fall is still taken before HOLD.
            if (ioctl_wr) begin
               if (wr_in_range) begin
                  lat_addr_nxt = ioctl_addr[AW-1:0];
                  lat_dat_nxt  = ioctl_dout;
                  state_nxt    = DL_WR;
               end else begin
                  dl_error_nxt = 1'b1;
               end
            end else if (!ioctl_download) begin
               state_nxt    = HOLD;
               hold_cnt_nxt = '0;
            end
         end
         DL_WR: begin
            if (slot_vld) begin
               // Skid byte is being written now; the slot frees once this write retires.
               slot_vld_nxt = 1'b0;
               state_nxt    = DL_IDLE;
               if (ioctl_wr)
                  dl_error_nxt = 1'b1;
            end else if (ioctl_wr && wr_in_range) begin
               // Captured byte goes straight to the latch so writes land on consecutive cycles.
               lat_addr_nxt = ioctl_addr[AW-1:0];
               lat_dat_nxt  = ioctl_dout;
               slot_vld_nxt = 1'b1;
            end else begin
               if (ioctl_wr)
                  dl_error_nxt = 1'b1;
               state_nxt = DL_IDLE;
            end
         end
         default: state_nxt = HOLD;
      endcase
   end

   always_comb begin
      core_din   = sram_dout;
      core_reset = (state != RUN);
      ioctl_wait = (state == DL_WR);
      if (state == RUN) begin
         sram_addr = core_addr;
         sram_we   = core_we;
         sram_din  = core_dout;
      end else begin
         sram_addr = lat_addr;
         sram_we   = (state == DL_WR);
         sram_din  = lat_dat;
      end
   end

endmodule

// File: tb/tb_ckong_sram_arbiter.sv
// Directed bench for ckong_sram_arbiter with a behavioural SRAM written on the falling clock edge.
module tb_ckong_sram_arbiter;

   logic        clk_sys;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        core_reset;
   logic [16:0] core_addr;
   logic        core_we;
   logic [7:0]  core_dout;
   logic [7:0]  core_din;
   logic [16:0] sram_addr;
   logic        sram_we;
   logic [7:0]  sram_din;
   logic [7:0]  sram_dout;
   logic        dl_error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wait_cnt = 0;
   int base;
   int wbase;

   logic [7:0]  mem [0:(1<<17)-1];
   logic [16:0] wa_q [$];
   logic [7:0]  wd_q [$];
   int          wc_q [$];

   ckong_sram_arbiter #(.AW(17), .RESET_HOLD(16)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .core_reset(core_reset),
      .core_addr(core_addr), .core_we(core_we), .core_dout(core_dout), .core_din(core_din),
      .sram_addr(sram_addr), .sram_we(sram_we), .sram_din(sram_din), .sram_dout(sram_dout),
      .dl_error(dl_error)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   assign sram_dout = mem[sram_addr];

   always @(posedge clk_sys) cyc++;

   always @(negedge clk_sys) begin
      if (ioctl_wait) wait_cnt++;
      if (sram_we) begin
         mem[sram_addr] <= sram_din;
         wa_q.push_back(sram_addr);
         wd_q.push_back(sram_din);
         wc_q.push_back(cyc);
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0; core_addr = '0; core_we = 1'b0; core_dout = '0;
      #22;
      chk("rst_core_reset", core_reset, 1);
      chk("rst_wait", ioctl_wait, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_dl_error", dl_error, 0);
      @(posedge clk_sys); #1;
      reset = 1'b0;

      tick(15);
      chk("hold_15", core_reset, 1);
      tick();
      chk("hold_16_run", core_reset, 0);

      core_addr = 17'h00100; core_dout = 8'h3C; core_we = 1'b1; #1;
      chk("core_we_pass", sram_we, 1);
      chk("core_addr_pass", sram_addr, 17'h00100);
      tick();
      core_we = 1'b0; #1;
      chk("core_read", core_din, 8'h3C);

      // Three spaced bytes
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      chk("dl_core_reset", core_reset, 1);
      base = wa_q.size(); wbase = wait_cnt;
      strobe(25'd0, 8'hA5);
      chk("b0_we", sram_we, 1);
      chk("b0_wait", ioctl_wait, 1);
      chk("b0_addr", sram_addr, 0);
      chk("b0_din", sram_din, 8'hA5);
      tick();
      chk("b0_wait_low", ioctl_wait, 0);
      chk("b0_we_low", sram_we, 0);
      tick(2);
      strobe(25'd1, 8'h5A);
      tick(3);
      strobe(25'd2, 8'hFF);
      tick(3);
      chk("spaced_pulses", wa_q.size() - base, 3);
      chk("spaced_wait", wait_cnt - wbase, 3);
      ioctl_download = 1'b0;
      tick(16);
      chk("end_hold_16", core_reset, 1);
      tick();
      chk("end_hold_run", core_reset, 0);
      core_addr = 17'd0; #1; chk("rd0", core_din, 8'hA5);
      core_addr = 17'd1; #1; chk("rd1", core_din, 8'h5A);
      core_addr = 17'd2; #1; chk("rd2", core_din, 8'hFF);

      // Back-to-back pair uses the skid slot
      ioctl_download = 1'b1;
      tick();
      base = wa_q.size(); wbase = wait_cnt;
      ioctl_wr = 1'b1; ioctl_addr = 25'd10; ioctl_dout = 8'h11;
      tick();
      ioctl_addr = 25'd11; ioctl_dout = 8'h22;
      tick();
      ioctl_wr = 1'b0;
      tick(3);
      chk("pair_count", wa_q.size() - base, 2);
      chk("pair_a0", wa_q[base], 10);
      chk("pair_d0", wd_q[base], 8'h11);
      chk("pair_a1", wa_q[base+1], 11);
      chk("pair_d1", wd_q[base+1], 8'h22);
      chk("pair_consec", wc_q[base+1] - wc_q[base], 1);
      chk("pair_wait", wait_cnt - wbase, 2);
      chk("pair_no_err", dl_error, 0);

      // Third consecutive strobe is dropped
      base = wa_q.size();
      ioctl_wr = 1'b1; ioctl_addr = 25'd20; ioctl_dout = 8'h44;
      tick();
      ioctl_addr = 25'd21; ioctl_dout = 8'h55;
      tick();
      ioctl_addr = 25'd22; ioctl_dout = 8'h66;
      tick();
      ioctl_wr = 1'b0;
      tick(3);
      chk("triple_err", dl_error, 1);
      chk("triple_count", wa_q.size() - base, 2);

      // New download start clears the error (restart from HOLD)
      ioctl_download = 1'b0;
      tick(2);
      chk("err_sticky", dl_error, 1);
      ioctl_download = 1'b1;
      tick();
      chk("err_cleared", dl_error, 0);

      // Out-of-range address
      base = wa_q.size();
      strobe(25'h20000, 8'h99);
      chk("oor_wait", ioctl_wait, 0);
      chk("oor_we", sram_we, 0);
      chk("oor_err", dl_error, 1);
      tick(2);
      chk("oor_no_write", wa_q.size() - base, 0);

      // Last strobe coincides with download fall
      ioctl_download = 1'b0;
      strobe(25'd5, 8'h77);
      chk("last_we", sram_we, 1);
      chk("last_addr", sram_addr, 17'd5);
      tick(17);
      chk("last_hold", core_reset, 1);
      tick();
      chk("last_run", core_reset, 0);
      core_addr = 17'd5; #1;
      chk("last_read", core_din, 8'h77);

      // Non-zero index is ignored
      ioctl_index = 8'd1; ioctl_download = 1'b1;
      tick(3);
      chk("idx1_run", core_reset, 0);
      core_addr = 17'h00200; core_dout = 8'hC3; core_we = 1'b1; #1;
      chk("idx1_core_we", sram_we, 1);
      core_we = 1'b0;
      ioctl_download = 1'b0;
      tick(2);

      // Async reset mid-download
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      tick();
      strobe(25'd30, 8'hEE);
      chk("abort_pre_we", sram_we, 1);
      reset = 1'b1; #1;
      chk("abort_we", sram_we, 0);
      chk("abort_wait", ioctl_wait, 0);
      chk("abort_core_reset", core_reset, 1);
      ioctl_download = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
